// File: rtl/regbank_pkg.sv
// Shared types and defaults for the arbitrated register bank.
package regbank_pkg;

    // Arbiter FSM encoding; the unused code 2'b11 falls back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int N_REQ_DEF  = 3;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    // Requester index width; wide enough for the maximum of 8 requesters.
    localparam int ID_W = 3;

endpackage

// File: rtl/regbank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
module rr_pick
    import regbank_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    int sh;

    // Scan from farthest to nearest so the nearest requester after ptr wins last.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        onehot = '0;
        idx    = '0;
        sh     = 0;
        valid  = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            sh = (int'(ptr) + k) % N_REQ;
            if (|(req & (N_REQ'(1) << sh))) begin
                onehot = N_REQ'(1) << sh;
                idx    = ID_W'(sh);
            end
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Register bank shared by N_REQ requesters, one access per IDLE/GRANT/DONE round.
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           we,
    input  logic [N_REQ*ADDR_W-1:0]    addr,
    input  logic [N_REQ*DATA_W-1:0]    wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic                       ack,
    output logic [ID_W-1:0]            ack_id,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic                 ack_q, ack_d;
    logic [ID_W-1:0]      ack_id_q, ack_id_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic [DATA_W-1:0]    bank_q [DEPTH];

    logic                 bank_we;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    logic [N_REQ-1:0]     pick_onehot;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_valid;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Route the granted requester's command fields using the one-hot grant.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                sel_we    = sel_we | we[i];
                sel_addr  = sel_addr | addr[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and output decode; holds everything unless a state acts on it.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        ack_d    = 1'b0;
        ack_id_d = ack_id_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        bank_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                if (pick_valid) begin
                    gnt_d   = pick_onehot;
                    ptr_d   = pick_idx;
                    busy_d  = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt_d    = '0;
                ack_d    = 1'b1;
                ack_id_d = ptr_q;
                busy_d   = 1'b1;
                state_d  = ST_DONE;
                if (sel_we) begin
                    bank_we = 1'b1;
                end else begin
                    rdata_d = bank_q[sel_addr];
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rstb) begin
            state_q  <= ST_IDLE;
            ptr_q    <= ID_W'(N_REQ - 1);
            gnt_q    <= '0;
            ack_q    <= 1'b0;
            ack_id_q <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            ack_id_q <= ack_id_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    // Bank storage; reset wins over a write landing on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: the bank is flip-flops that must read zero after reset, so every word is cleared.
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bank_we) begin
            bank_q[sel_addr] <= sel_wdata;
        end
    end

    assign gnt    = gnt_q;
    assign ack    = ack_q;
    assign ack_id = ack_id_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter with hand-computed expectations.
module tb_regbank_arbiter;

    localparam int N = 3;
    localparam int DW = 8;
    localparam int AW = 3;

    logic            clk;
    logic            rstb;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic            ack;
    logic [2:0]      ack_id;
    logic [DW-1:0]   rdata;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    regbank_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk    (clk),
        .rstb   (rstb),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .ack    (ack),
        .ack_id (ack_id),
        .rdata  (rdata),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One single access from requester id starting in an IDLE cycle, checked at every cycle.
    task automatic do_access(input int id, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                             input string tag);
        logic [N-1:0] exp_gnt;
        exp_gnt = N'(1) << id;
        we[id] = wr;
        addr[id*AW +: AW] = a;
        wdata[id*DW +: DW] = d;
        req[id] = 1'b1;
        step();
        checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL %s gnt: got %b want %b", tag, gnt, exp_gnt); end
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL %s early ack: got %b want 0", tag, ack); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s busy grant: got %b want 1", tag, busy); end
        step();
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL %s ack: got %b want 1", tag, ack); end
        checks++; if (ack_id !== 3'(id)) begin failures++; $display("FAIL %s ack_id: got %0d want %0d", tag, ack_id, id); end
        checks++; if (rdata !== exp_rd) begin failures++; $display("FAIL %s rdata: got %h want %h", tag, rdata, exp_rd); end
        checks++; if (gnt !== '0) begin failures++; $display("FAIL %s gnt in done: got %b want 000", tag, gnt); end
        req[id] = 1'b0;
        step();
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL %s ack clear: got %b want 0", tag, ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s busy idle: got %b want 0", tag, busy); end
    endtask

    task automatic test_reset();
        rstb = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) step();
        rstb = 1'b1;
        checks++; if (gnt !== '0) begin failures++; $display("FAIL reset gnt: got %b want 000", gnt); end
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset ack: got %b want 0", ack); end
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset rdata: got %h want 00", rdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (ack_id !== 3'd0) begin failures++; $display("FAIL reset ack_id: got %0d want 0", ack_id); end
        // Pointer resets to N-1 so requester 0 is first; bank word 5 is zero.
        do_access(0, 1'b0, 3'd5, 8'h00, 8'h00, "reset_read5");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (ack !== 1'b0 || gnt !== '0) begin failures++; $display("FAIL idle cycle %0d: ack=%b gnt=%b want 0/000", i, ack, gnt); end
        end
    endtask

    task automatic test_write_read();
        do_access(0, 1'b1, 3'd3, 8'hA5, 8'h00, "wr_addr3");
        do_access(0, 1'b0, 3'd3, 8'h00, 8'hA5, "rd_addr3");
    endtask

    task automatic test_contention();
        int          exp_id [6];
        logic [N-1:0] exp_g;
        exp_id = '{0, 1, 2, 0, 1, 2};
        // Put the pointer on requester 2 so the rotation starts at 0.
        do_access(2, 1'b1, 3'd6, 8'h66, 8'hA5, "wr_addr6_r2");
        we = 3'b111;
        addr = {3'd2, 3'd1, 3'd0};
        wdata = {8'h33, 8'h22, 8'h11};
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_g = N'(1) << exp_id[k];
            step();
            checks++; if (gnt !== exp_g) begin failures++; $display("FAIL contention grant %0d: got %b want %b", k, gnt, exp_g); end
            step();
            checks++; if (ack !== 1'b1 || ack_id !== 3'(exp_id[k])) begin failures++; $display("FAIL contention ack %0d: ack=%b id=%0d want 1/%0d", k, ack, ack_id, exp_id[k]); end
            checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL contention rdata hold %0d: got %h want a5", k, rdata); end
            if (k == 5) req = '0;
            step();
            checks++; if (gnt !== '0 || ack !== 1'b0) begin failures++; $display("FAIL contention idle %0d: gnt=%b ack=%b want 000/0", k, gnt, ack); end
        end
    endtask

    task automatic test_pointer_wrap();
        we = '0;
        addr = {3'd2, 3'd0, 3'd1};
        req = 3'b101;
        step();
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL wrap first gnt: got %b want 001", gnt); end
        step();
        checks++; if (ack_id !== 3'd0 || rdata !== 8'h22) begin failures++; $display("FAIL wrap first ack: id=%0d rdata=%h want 0/22", ack_id, rdata); end
        step();
        step();
        checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL wrap second gnt: got %b want 100", gnt); end
        step();
        checks++; if (ack_id !== 3'd2 || rdata !== 8'h33) begin failures++; $display("FAIL wrap second ack: id=%0d rdata=%h want 2/33", ack_id, rdata); end
        req = '0;
        step();
    endtask

    task automatic test_reset_mid();
        we[1] = 1'b1;
        addr[1*AW +: AW] = 3'd7;
        wdata[1*DW +: DW] = 8'h3C;
        req = 3'b010;
        step();
        checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL midreset gnt: got %b want 010", gnt); end
        rstb = 1'b0;
        step();
        checks++; if (ack !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin failures++; $display("FAIL midreset outputs: ack=%b gnt=%b busy=%b want 0/000/0", ack, gnt, busy); end
        rstb = 1'b1;
        req = '0;
        step();
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL midreset late ack: got %b want 0", ack); end
        do_access(0, 1'b0, 3'd7, 8'h00, 8'h00, "midreset_rd7");
        do_access(0, 1'b0, 3'd3, 8'h00, 8'h00, "midreset_rd3");
    endtask

    task automatic test_late_request();
        we = 3'b101;
        addr = {3'd5, 3'd0, 3'd4};
        wdata = {8'h55, 8'h00, 8'h44};
        req = 3'b001;
        step();
        checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL late gnt0: got %b want 001", gnt); end
        step();
        checks++; if (ack !== 1'b1 || ack_id !== 3'd0) begin failures++; $display("FAIL late ack0: ack=%b id=%0d want 1/0", ack, ack_id); end
        req = 3'b100;
        step();
        checks++; if (gnt !== '0) begin failures++; $display("FAIL late grant from done: got %b want 000", gnt); end
        step();
        checks++; if (gnt !== 3'b100) begin failures++; $display("FAIL late gnt2: got %b want 100", gnt); end
        step();
        checks++; if (ack !== 1'b1 || ack_id !== 3'd2) begin failures++; $display("FAIL late ack2: ack=%b id=%0d want 1/2", ack, ack_id); end
        req = '0;
        step();
        do_access(0, 1'b0, 3'd5, 8'h00, 8'h55, "late_rd5");
        do_access(1, 1'b0, 3'd4, 8'h00, 8'h44, "late_rd4");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write_read();
        test_contention();
        test_pointer_wrap();
        test_reset_mid();
        test_late_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
